// File: rtl/pi_permute_engine.sv
// Multi-pass pi lane permutation engine: loads DIM x DIM bit lines, permutes them PASSES times,
// and emits them over valid/ready. Optional inverse mode via `define PI_INVERSE_EN (adds port inv).
module pi_permute_engine #(
  parameter int DIM        = 5,
  parameter int NUM_SLICES = 64,
  parameter int PASSES     = 1,
  localparam int W         = DIM * DIM,
  localparam int SW        = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [W-1:0]  in_line,
  output logic          in_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_line,
  input  logic          out_ready,
`ifdef PI_INVERSE_EN
  input  logic          inv,
`endif
  output logic          busy,
  output logic          done,
  output logic [SW-1:0] slice_idx,
  output logic [1:0]    fsm_state
);

  localparam int PW = (PASSES > 1) ? $clog2(PASSES + 1) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] PERM = 2'd2;
  localparam logic [1:0] EMIT = 2'd3;

  localparam logic [PW-1:0] PASS_LAST  = PW'(PASSES - 1);
  localparam logic [SW-1:0] SLICE_LAST = SW'(NUM_SLICES - 1);

  logic [1:0]    state_q;
  logic [W-1:0]  line_q;
  logic [SW-1:0] slice_q;
  logic [PW-1:0] pass_q;
  logic          done_q;
  logic [W-1:0]  pi_fwd;
  logic [W-1:0]  step;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // out_valid/out_line stay stable until that edge, and in_ready is high only in LOAD.

  // Output bit o = x + DIM*y takes input lane ((x+3y) mod DIM, x); pure wiring.
  for (genvar o = 0; o < W; o++) begin : g_pi
    localparam int X   = o % DIM;
    localparam int Y   = o / DIM;
    localparam int SRC = ((X + 3 * Y) % DIM) + DIM * X;
    assign pi_fwd[o] = line_q[SRC];
  end

`ifdef PI_INVERSE_EN
  logic [W-1:0] pi_inv;
  logic         inv_q;

  // Inverse scatters each bit back to the lane it was gathered from.
  for (genvar o = 0; o < W; o++) begin : g_pi_inv
    localparam int X   = o % DIM;
    localparam int Y   = o / DIM;
    localparam int SRC = ((X + 3 * Y) % DIM) + DIM * X;
    assign pi_inv[SRC] = line_q[o];
  end

  assign step = inv_q ? pi_inv : pi_fwd;

  always_ff @(posedge clk) begin
    if (rst) begin
      inv_q <= 1'b0;
    end else if (state_q == LOAD && in_valid) begin
      inv_q <= inv;
    end
  end
`else
  assign step = pi_fwd;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      line_q  <= '0;
      slice_q <= '0;
      pass_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD;
            slice_q <= '0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            line_q  <= in_line;
            pass_q  <= '0;
            state_q <= PERM;
          end
        end
        PERM: begin
          line_q <= step;
          pass_q <= pass_q + PW'(1);
          if (pass_q == PASS_LAST) begin
            state_q <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (slice_q == SLICE_LAST) begin
              state_q <= IDLE;
              slice_q <= '0;
              done_q  <= 1'b1;
            end else begin
              slice_q <= slice_q + SW'(1);
              state_q <= LOAD;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == EMIT);
  assign out_line  = line_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign slice_idx = slice_q;
  assign fsm_state = state_q;

endmodule
